mult_sequencer: RTL and testbench

//  Multi-cycle 32x32->64 shift-add multiplier controller that time-shares one external

---
 rtl/mult_sequencer_pkg.sv | 34 +++
 rtl/mult_sequencer_if.sv | 25 ++
 rtl/mult_sequencer_shift_reg.sv | 89 ++++++++
 rtl/mult_sequencer.sv | 178 +++++++++++++++++
 tb/tb_mult_sequencer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
//   - ms_state_e : FSM state encoding (3 bits)
//   - WIDTH      : operand width, fixed at 32 by the external adder
//   - CNT_W      : iteration counter width (holds 0..WIDTH)
//   - MULT_ITERS : number of shift-add iterations per multiply
package mult_sequencer_pkg;

  localparam int WIDTH      = 32;
  localparam int CNT_W      = 6;
  localparam int MULT_ITERS = 32;

  typedef enum logic [2:0] {
    MS_IDLE   = 3'd0,
    MS_NEG_A  = 3'd1,
    MS_NEG_B  = 3'd2,
    MS_ITER   = 3'd3,
    MS_NEG_LO = 3'd4,
    MS_NEG_HI = 3'd5,
    MS_DONE   = 3'd6
  } ms_state_e;

  // Product is negative only for a signed multiply with operands of differing sign.
  function automatic logic result_negative(input logic is_signed,
                                           input logic a_msb,
                                           input logic b_msb);
    return is_signed & (a_msb ^ b_msb);
  endfunction

  // True on the final shift-add iteration.
  function automatic logic is_last_iter(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_W'(MULT_ITERS - 1));
  endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Request/result bus of the multiplier sequencer.
//   master : start, is_signed, a, b out; busy, done, product_hi/lo in
//   slave  : the mirror image, used by mult_sequencer
interface mult_sequencer_if;
  import mult_sequencer_pkg::*;

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, product_hi, product_lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, product_hi, product_lo
  );
endinterface

// File: rtl/mult_sequencer_shift_reg.sv
// Datapath registers of the multiplier: hi/lo partial product, multiplicand and the
// borrow flag carried from the low-word negate to the high-word negate.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   load, a_in, b_in      capture operands (hi=0, lo=b, mcand=a)
//   shift                 {hi,lo} <= {add_cout, add_out, lo[31:1]}
//   wr_mcand/wr_lo/wr_hi  overwrite that register with add_out
//   wr_borrow             borrow_n <= add_cout
//   add_out, add_cout     result of the shared adder
//   hi, lo, mcand, borrow_n  current register values
//   hi_nxt, lo_nxt        values being written this edge (used to capture the product)
module mult_shift_reg
  import mult_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             shift,
  input  logic             wr_mcand,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic             wr_borrow,
  input  logic [WIDTH-1:0] add_out,
  input  logic             add_cout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mcand,
  output logic             borrow_n,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH-1:0] hi_r, lo_r, mcand_r;
  logic             borrow_r;
  logic [WIDTH-1:0] hi_nxt_s, lo_nxt_s, mcand_nxt_s;
  logic             borrow_nxt_s;

  // Next-value selection: load, shift, then the individual write enables.
  always_comb begin
    hi_nxt_s     = hi_r;
    lo_nxt_s     = lo_r;
    mcand_nxt_s  = mcand_r;
    borrow_nxt_s = borrow_r;
    if (load) begin
      hi_nxt_s     = {WIDTH{1'b0}};
      lo_nxt_s     = b_in;
      mcand_nxt_s  = a_in;
      borrow_nxt_s = 1'b0;
    end else if (shift) begin
      // Carry-out becomes the new hi MSB so the 33-bit partial sum is never truncated.
      hi_nxt_s = {add_cout, add_out[WIDTH-1:1]};
      lo_nxt_s = {add_out[0], lo_r[WIDTH-1:1]};
    end else begin
      if (wr_mcand) mcand_nxt_s = add_out;
      else          mcand_nxt_s = mcand_r;
      if (wr_lo)    lo_nxt_s = add_out;
      else          lo_nxt_s = lo_r;
      if (wr_hi)    hi_nxt_s = add_out;
      else          hi_nxt_s = hi_r;
      if (wr_borrow) borrow_nxt_s = add_cout;
      else           borrow_nxt_s = borrow_r;
    end
  end

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
    end else begin
      hi_r     <= hi_nxt_s;
      lo_r     <= lo_nxt_s;
      mcand_r  <= mcand_nxt_s;
      borrow_r <= borrow_nxt_s;
    end
  end

  assign hi       = hi_r;
  assign lo       = lo_r;
  assign mcand    = mcand_r;
  assign borrow_n = borrow_r;
  assign hi_nxt   = hi_nxt_s;
  assign lo_nxt   = lo_nxt_s;

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle 32x32->64 shift-add multiplier (MULT/MULTU) that time-shares one external
// AdderSubtractor. Signed operands are converted to magnitudes, multiplied unsigned and
// the 64-bit result negated when the signs differ. Latency is data independent:
// done 33 edges after the accepting edge for unsigned, 37 for signed.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   bus (slave)          start/is_signed/a/b request, busy/done/product_hi/product_lo result
//   add_a, add_b         adder operands
//   add_ctl0             1 = subtract
//   add_ctl1             always 0
//   add_out, add_cout    adder result and carry-out
module mult_sequencer
  import mult_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  mult_sequencer_if.slave  bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ctl0,
  output logic             add_ctl1,
  input  logic [WIDTH-1:0] add_out,
  input  logic             add_cout
);

  ms_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             is_signed_r;
  logic             sign_res_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] prod_hi_r, prod_lo_r;

  logic             load_s, shift_s, wr_mcand_s, wr_lo_s, wr_hi_s, wr_borrow_s;
  logic [WIDTH-1:0] hi_s, lo_s, mcand_s, hi_nxt_s, lo_nxt_s;
  logic             borrow_n_s;

  // Datapath control strobes decoded from the current state.
  always_comb begin
    load_s      = (state_r == MS_IDLE) && bus.start;
    shift_s     = (state_r == MS_ITER);
    wr_mcand_s  = (state_r == MS_NEG_A) && mcand_s[WIDTH-1];
    wr_lo_s     = ((state_r == MS_NEG_B) && lo_s[WIDTH-1]) ||
                  ((state_r == MS_NEG_LO) && sign_res_r);
    wr_borrow_s = (state_r == MS_NEG_LO) && sign_res_r;
    wr_hi_s     = (state_r == MS_NEG_HI) && sign_res_r;
  end

  // Adder input muxing; idle and done states present zeros.
  always_comb begin
    add_a    = {WIDTH{1'b0}};
    add_b    = {WIDTH{1'b0}};
    add_ctl0 = 1'b0;
    case (state_r)
      MS_NEG_A: begin
        add_b    = mcand_s;
        add_ctl0 = 1'b1;
      end
      MS_NEG_B: begin
        add_b    = lo_s;
        add_ctl0 = 1'b1;
      end
      MS_ITER: begin
        add_a = hi_s;
        add_b = lo_s[0] ? mcand_s : {WIDTH{1'b0}};
      end
      MS_NEG_LO: begin
        add_b    = lo_s;
        add_ctl0 = 1'b1;
      end
      MS_NEG_HI: begin
        // Ones' complement of hi unless the low word was zero (borrow_n set): two's complement.
        add_a    = borrow_n_s ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        add_b    = hi_s;
        add_ctl0 = 1'b1;
      end
      default: begin
        add_a    = {WIDTH{1'b0}};
        add_b    = {WIDTH{1'b0}};
        add_ctl0 = 1'b0;
      end
    endcase
  end

  assign add_ctl1 = 1'b0;

  mult_shift_reg u_shift_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .a_in      (bus.a),
    .b_in      (bus.b),
    .shift     (shift_s),
    .wr_mcand  (wr_mcand_s),
    .wr_lo     (wr_lo_s),
    .wr_hi     (wr_hi_s),
    .wr_borrow (wr_borrow_s),
    .add_out   (add_out),
    .add_cout  (add_cout),
    .hi        (hi_s),
    .lo        (lo_s),
    .mcand     (mcand_s),
    .borrow_n  (borrow_n_s),
    .hi_nxt    (hi_nxt_s),
    .lo_nxt    (lo_nxt_s)
  );

  // Sequencer FSM, iteration counter and registered status/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= MS_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      is_signed_r <= 1'b0;
      sign_res_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      prod_hi_r   <= {WIDTH{1'b0}};
      prod_lo_r   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        MS_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            is_signed_r <= bus.is_signed;
            sign_res_r  <= result_negative(bus.is_signed, bus.a[WIDTH-1], bus.b[WIDTH-1]);
            cnt_r       <= {CNT_W{1'b0}};
            busy_r      <= 1'b1;
            state_r     <= bus.is_signed ? MS_NEG_A : MS_ITER;
          end else begin
            state_r <= MS_IDLE;
          end
        end
        MS_NEG_A: state_r <= MS_NEG_B;
        MS_NEG_B: state_r <= MS_ITER;
        MS_ITER: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (is_last_iter(cnt_r)) begin
            if (is_signed_r) begin
              state_r <= MS_NEG_LO;
            end else begin
              // Finish: the product is taken from the values being written this edge.
              state_r   <= MS_DONE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              prod_hi_r <= hi_nxt_s;
              prod_lo_r <= lo_nxt_s;
            end
          end else begin
            state_r <= MS_ITER;
          end
        end
        MS_NEG_LO: state_r <= MS_NEG_HI;
        MS_NEG_HI: begin
          state_r   <= MS_DONE;
          busy_r    <= 1'b0;
          done_r    <= 1'b1;
          prod_hi_r <= hi_nxt_s;
          prod_lo_r <= lo_nxt_s;
        end
        MS_DONE: begin
          done_r  <= 1'b0;
          state_r <= MS_IDLE;
        end
        default: begin
          state_r <= MS_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.product_hi = prod_hi_r;
  assign bus.product_lo = prod_lo_r;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer with a behavioural AdderSubtractor model.
module tb_mult_sequencer;
  import mult_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] add_a, add_b, add_out;
  logic        add_ctl0, add_ctl1, add_cout;
  logic [32:0] sum_s;

  always #5 clk = ~clk;

  mult_sequencer_if bus ();

  mult_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_ctl0 (add_ctl0),
    .add_ctl1 (add_ctl1),
    .add_out  (add_out),
    .add_cout (add_cout)
  );

  // AdderSubtractor model: subtract is A + ~B + 1, Cout is the 33rd bit.
  always_comb begin
    if (add_ctl0) sum_s = {1'b0, add_a} + {1'b0, ~add_b} + 33'd1;
    else          sum_s = {1'b0, add_a} + {1'b0, add_b};
  end
  assign add_out  = sum_s[31:0];
  assign add_cout = sum_s[32];

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    time         t0;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: count busy cycles and compare each done against the scoreboard head.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("product_hi", {32'd0, bus.product_hi}, {32'd0, mon_e.hi});
          check("product_lo", {32'd0, bus.product_lo}, {32'd0, mon_e.lo});
          check("latency", 64'(($time - mon_e.t0 + 5) / 10), 64'(mon_e.lat));
          check("busy_cycles", 64'(busy_cnt), 64'(mon_e.lat - 1));
          check("busy_at_done", {63'd0, bus.busy}, 64'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic is_s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = is_s;
    bus.a         = a;
    bus.b         = b;
    @(posedge clk);
    e.hi  = hi;
    e.lo  = lo;
    e.lat = is_s ? 37 : 33;
    e.t0  = $time;
    exp_q.push_back(e);
    #1;
    bus.start     = 1'b0;
    bus.is_signed = ~is_s;
    bus.a         = 32'hDEADBEEF;
    bus.b         = 32'h5A5A5A5A;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic is_s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
    issue(is_s, a, b, hi, lo);
    wait_drain();
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_product", {bus.product_hi, bus.product_lo}, 64'd0);
    check("rst_add_a", {32'd0, add_a}, 64'd0);
    check("rst_add_b", {32'd0, add_b}, 64'd0);
    check("rst_ctl", {62'd0, add_ctl1, add_ctl0}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Unsigned
    run_op(1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op(1'b0, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000);
    // Signed
    run_op(1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op(1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op(1'b1, 32'hFFFFFFFF, 32'd0,        32'h00000000, 32'h00000000);
    run_op(1'b1, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6);
    run_op(1'b1, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780);

    // Start while busy is ignored: one done, first result.
    issue(1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (40) @(posedge clk);

    // Reset mid-operation aborts.
    issue(1'b1, 32'd11, 32'd13, 32'h00000000, 32'd143);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_product", {bus.product_hi, bus.product_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, 32'd7, 32'd6, 32'h00000000, 32'd42);

    repeat (5) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
